// File: rtl/rrc_interp_fir.sv
// Dual-channel (I/Q) root-raised-cosine FIR with SPS zero-stuff interpolation,
// runtime-loadable coefficients, scaled/saturated outputs and valid/ready
// handshakes on both the symbol input and the sample output.
module rrc_interp_fir #(
    parameter int DIN_W  = 4,
    parameter int COEF_W = 8,
    parameter int DOUT_W = 16,
    parameter int TAPS   = 11,
    parameter int SPS    = 4,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DIN_W-1:0]         din_i,
    input  logic [DIN_W-1:0]         din_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DOUT_W-1:0]        dout_i,
    output logic [DOUT_W-1:0]        dout_q,
    output logic                     sat,
    input  logic                     coef_wr,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic                     coef_err
);

    localparam int AW     = $clog2(TAPS);
    localparam int PH_W   = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int ACC_W  = DIN_W + COEF_W + $clog2(TAPS);
    localparam int EXT_W  = ((ACC_W > DOUT_W) ? ACC_W : DOUT_W) + 1;
    localparam int CENTER = (TAPS - 1) / 2;

    localparam logic [PH_W-1:0]          PH_LAST     = PH_W'(SPS - 1);
    localparam logic [AW:0]              TAPS_V      = (AW + 1)'(TAPS);
    localparam logic signed [COEF_W-1:0] COEF_CENTER = COEF_W'(2 ** (COEF_W - 2));
    localparam logic signed [EXT_W-1:0]  MAX_V = {{(EXT_W - DOUT_W + 1){1'b0}}, {(DOUT_W - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0]  MIN_V = {{(EXT_W - DOUT_W + 1){1'b1}}, {(DOUT_W - 1){1'b0}}};

    logic [PH_W-1:0]           phase_q, phase_d;
    logic signed [DIN_W-1:0]   sh_i_q [TAPS];
    logic signed [DIN_W-1:0]   sh_i_d [TAPS];
    logic signed [DIN_W-1:0]   sh_q_q [TAPS];
    logic signed [DIN_W-1:0]   sh_q_d [TAPS];
    logic signed [COEF_W-1:0]  coef_q [TAPS];
    logic signed [COEF_W-1:0]  coef_d [TAPS];
    logic signed [DOUT_W-1:0]  dout_i_q, dout_i_d;
    logic signed [DOUT_W-1:0]  dout_q_q, dout_q_d;
    logic                      out_valid_q, out_valid_d;
    logic                      sat_q, sat_d;
    logic                      coef_err_q, coef_err_d;

    logic                      phase_zero, slot_free, step, coef_ok;
    logic signed [ACC_W-1:0]   acc_i, acc_q;
    logic signed [EXT_W-1:0]   scl_i, scl_q;
    logic [DOUT_W:0]           res_i, res_q;

    // Clip a scaled accumulator into the output range; MSB flags clipping.
    function automatic logic [DOUT_W:0] saturate(input logic signed [EXT_W-1:0] v);
        if (v > MAX_V) begin
            return {1'b1, MAX_V[DOUT_W-1:0]};
        end else if (v < MIN_V) begin
            return {1'b1, MIN_V[DOUT_W-1:0]};
        end
        return {1'b0, v[DOUT_W-1:0]};
    endfunction

    // Handshake: a step advances the interpolator one output sample.
    always_comb begin
        phase_zero = (phase_q == '0);
        slot_free  = !out_valid_q || out_ready;
        step       = slot_free && (!phase_zero || in_valid);
        in_ready   = phase_zero && slot_free;
    end

    // Delay lines and phase counter; a new symbol enters only at phase 0.
    always_comb begin
        phase_d = phase_q;
        for (int unsigned k = 0; k < TAPS; k++) begin
            sh_i_d[k] = sh_i_q[k];
            sh_q_d[k] = sh_q_q[k];
        end
        if (step) begin
            sh_i_d[0] = phase_zero ? $signed(din_i) : '0;
            sh_q_d[0] = phase_zero ? $signed(din_q) : '0;
            for (int unsigned k = 1; k < TAPS; k++) begin
                sh_i_d[k] = sh_i_q[k-1];
                sh_q_d[k] = sh_q_q[k-1];
            end
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        end
    end

    // Coefficient writes only land while idle at a symbol boundary.
    always_comb begin
        coef_ok    = coef_wr && phase_zero && !step && ({1'b0, coef_addr} < TAPS_V);
        coef_err_d = coef_wr && !coef_ok;
        for (int unsigned k = 0; k < TAPS; k++) begin
            coef_d[k] = coef_q[k];
        end
        if (coef_ok) begin
            coef_d[coef_addr] = $signed(coef_data);
        end
    end

    // Multiply-accumulate over the post-shift delay-line contents.
    always_comb begin
        acc_i = '0;
        acc_q = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            acc_i = acc_i + ACC_W'(sh_i_d[k]) * ACC_W'(coef_q[k]);
            acc_q = acc_q + ACC_W'(sh_q_d[k]) * ACC_W'(coef_q[k]);
        end
        scl_i = EXT_W'(acc_i) >>> SHIFT;
        scl_q = EXT_W'(acc_q) >>> SHIFT;
        res_i = saturate(scl_i);
        res_q = saturate(scl_q);
    end

    // Output register: load on a step, drop valid when the slot drains idle.
    always_comb begin
        out_valid_d = out_valid_q;
        dout_i_d    = dout_i_q;
        dout_q_d    = dout_q_q;
        sat_d       = sat_q;
        if (step) begin
            out_valid_d = 1'b1;
            dout_i_d    = res_i[DOUT_W-1:0];
            dout_q_d    = res_q[DOUT_W-1:0];
            sat_d       = res_i[DOUT_W] || res_q[DOUT_W];
        end else if (slot_free) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset restores the centre-tap impulse coefficients.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= '0;
            out_valid_q <= 1'b0;
            dout_i_q    <= '0;
            dout_q_q    <= '0;
            sat_q       <= 1'b0;
            coef_err_q  <= 1'b0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                sh_i_q[k] <= '0;
                sh_q_q[k] <= '0;
                coef_q[k] <= (k == CENTER) ? COEF_CENTER : '0;
            end
        end else begin
            phase_q     <= phase_d;
            out_valid_q <= out_valid_d;
            dout_i_q    <= dout_i_d;
            dout_q_q    <= dout_q_d;
            sat_q       <= sat_d;
            coef_err_q  <= coef_err_d;
            for (int unsigned k = 0; k < TAPS; k++) begin
                sh_i_q[k] <= sh_i_d[k];
                sh_q_q[k] <= sh_q_d[k];
                coef_q[k] <= coef_d[k];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign dout_i    = dout_i_q;
    assign dout_q    = dout_q_q;
    assign sat       = sat_q;
    assign coef_err  = coef_err_q;

endmodule
